iccm_uart_loader: RTL

- Boot-time program loader that sits directly upstream of the instruction memory (ICCM).
- Receives a program image over a UART RX line and assembles little-endian 32-bit words.
- Drives the ICCM write port (write enable, address, data) and holds the core in reset until the image is fully written.
- After loading, the ICCM address mux returns to the core fetch path.

---
 rtl/iccm_uart_loader.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/iccm_uart_loader.sv
// Boot loader: receives a length-prefixed little-endian image over UART and writes it into the ICCM.
// Optional trailing XOR checksum byte is enabled by defining LOADER_CHECKSUM_EN.
module iccm_uart_loader #(
   parameter int DataWidth  = 32,
   parameter int AddrWidth  = 15,
   parameter int ClksPerBit = 434
) (
   input  logic                 brq_clk,
   input  logic                 brq_rst,
   input  logic                 uart_rx,
   output logic                 iccm_we,
   output logic [AddrWidth-1:0] iccm_addr,
   output logic [DataWidth-1:0] iccm_wdata,
   output logic                 core_hold,
   output logic                 load_done,
   output logic                 frame_err,
`ifdef LOADER_CHECKSUM_EN
   output logic                 ovf_err,
   output logic                 csum_err
`else
   output logic                 ovf_err
`endif
);

   localparam int CntW = $clog2(ClksPerBit);
   localparam logic [CntW-1:0] BitMax  = CntW'(ClksPerBit - 1);
   localparam logic [CntW-1:0] HalfMax = CntW'(ClksPerBit / 2 - 1);

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
   typedef enum logic [1:0] {LD_LEN, LD_DATA, LD_CSUM, LD_DONE} ld_state_t;

   logic            rx_meta, rx_sync, rx_prev;
   rx_state_t       rx_state;
   logic [CntW-1:0] clk_cnt;
   logic [2:0]      bit_idx;
   logic [7:0]      rx_shift;
   logic [7:0]      rx_byte;
   logic            byte_valid;

   ld_state_t       ld_state;
   logic [1:0]      byte_cnt;
   logic [23:0]     word_buf;
   logic [31:0]     word_count;
   logic [31:0]     word_idx;
   logic            finish_pending;
   logic [31:0]     full_word;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]      csum;
`endif

   assign full_word = {rx_byte, word_buf};

   always_ff @(posedge brq_clk or negedge brq_rst) begin
      if (!brq_rst) begin
         rx_meta    <= 1'b1;
         rx_sync    <= 1'b1;
         rx_prev    <= 1'b1;
         rx_state   <= RX_IDLE;
         clk_cnt    <= '0;
         bit_idx    <= '0;
         rx_shift   <= '0;
         rx_byte    <= '0;
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         rx_meta    <= uart_rx;
         rx_sync    <= rx_meta;
         rx_prev    <= rx_sync;
         byte_valid <= 1'b0;
         case (rx_state)
            RX_IDLE: begin
               clk_cnt <= '0;
               bit_idx <= '0;
               if (rx_prev && !rx_sync) rx_state <= RX_START;
            end
            RX_START: begin
               if (clk_cnt == HalfMax) begin
                  clk_cnt  <= '0;
                  rx_state <= rx_sync ? RX_IDLE : RX_DATA;
               end else begin
                  clk_cnt <= clk_cnt + 1'b1;
               end
            end
            RX_DATA: begin
               if (clk_cnt == BitMax) begin
                  clk_cnt  <= '0;
                  rx_shift <= {rx_sync, rx_shift[7:1]};
                  bit_idx  <= bit_idx + 1'b1;
                  if (bit_idx == 3'd7) rx_state <= RX_STOP;
               end else begin
                  clk_cnt <= clk_cnt + 1'b1;
               end
            end
            RX_STOP: begin
               if (clk_cnt == BitMax) begin
                  clk_cnt  <= '0;
                  rx_state <= RX_IDLE;
                  if (rx_sync) begin
                     byte_valid <= 1'b1;
                     rx_byte    <= rx_shift;
                  end else begin
                     frame_err <= 1'b1;
                  end
               end else begin
                  clk_cnt <= clk_cnt + 1'b1;
               end
            end
            default: rx_state <= RX_IDLE;
         endcase
      end
   end

   // finish_pending delays DONE by one cycle so load_done follows the final write strobe.
   always_ff @(posedge brq_clk or negedge brq_rst) begin
      if (!brq_rst) begin
         ld_state       <= LD_LEN;
         byte_cnt       <= '0;
         word_buf       <= '0;
         word_count     <= '0;
         word_idx       <= '0;
         finish_pending <= 1'b0;
         iccm_we        <= 1'b0;
         iccm_addr      <= '0;
         iccm_wdata     <= '0;
         core_hold      <= 1'b1;
         load_done      <= 1'b0;
         ovf_err        <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
         csum           <= '0;
         csum_err       <= 1'b0;
`endif
      end else begin
         iccm_we <= 1'b0;
         if (finish_pending) begin
            finish_pending <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            ld_state       <= LD_CSUM;
`else
            ld_state       <= LD_DONE;
            load_done      <= 1'b1;
            core_hold      <= 1'b0;
`endif
         end else if (byte_valid) begin
            case (ld_state)
               LD_LEN: begin
                  byte_cnt <= byte_cnt + 1'b1;
                  word_buf <= {rx_byte, word_buf[23:8]};
                  if (byte_cnt == 2'd3) begin
                     word_count <= full_word;
                     if (full_word == 32'd0) begin
                        ld_state  <= LD_DONE;
                        load_done <= 1'b1;
                        core_hold <= 1'b0;
                     end else begin
                        ld_state <= LD_DATA;
                     end
                  end
               end
               LD_DATA: begin
                  byte_cnt <= byte_cnt + 1'b1;
                  word_buf <= {rx_byte, word_buf[23:8]};
`ifdef LOADER_CHECKSUM_EN
                  csum     <= csum ^ rx_byte;
`endif
                  if (byte_cnt == 2'd3) begin
                     if (word_idx[31:AddrWidth] == '0) begin
                        iccm_we    <= 1'b1;
                        iccm_addr  <= word_idx[AddrWidth-1:0];
                        iccm_wdata <= full_word;
                     end else begin
                        ovf_err <= 1'b1;
                     end
                     word_idx <= word_idx + 32'd1;
                     if (word_idx == word_count - 32'd1) finish_pending <= 1'b1;
                  end
               end
`ifdef LOADER_CHECKSUM_EN
               LD_CSUM: begin
                  // a mismatch parks in DONE with the core still held
                  ld_state <= LD_DONE;
                  if (rx_byte == csum) begin
                     load_done <= 1'b1;
                     core_hold <= 1'b0;
                  end else begin
                     csum_err <= 1'b1;
                  end
               end
`endif
               default: ;
            endcase
         end
      end
   end

endmodule
